// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg : shared widths, port identifiers and read-tag type for ram_arbiter
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

  localparam int C_ADDR_W = 8;
  localparam int C_DATA_W = 8;
  localparam int C_RD_LAT = 2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_rdpipe.sv
// ----------------------------------------------------------------------------
// ram_arb_rdpipe : read-tag delay line matching RAM latency, steers ram_q to owner
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ram_arb_rdpipe
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int RD_LAT = C_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  tag_t              i_tag,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata
);

  tag_t              r_tag [RD_LAT];
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  tag_t              w_out;
  logic              w_hit_a;
  logic              w_hit_b;

  assign w_out   = r_tag[RD_LAT-1];
  assign w_hit_a = w_out.valid && (w_out.port == PORT_A);
  assign w_hit_b = w_out.valid && (w_out.port == PORT_B);

  // Clearing the tags on reset is what discards reads still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_a_rvalid <= w_hit_a;
      r_b_rvalid <= w_hit_b;
      if (w_hit_a) r_a_rdata <= i_ram_q;
      if (w_hit_b) r_b_rdata <= i_ram_q;
    end
  end

  assign o_a_rvalid = r_a_rvalid;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rvalid = r_b_rvalid;
  assign o_b_rdata  = r_b_rdata;

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter : round-robin two-port arbiter for a single-port RAM
//               (optional RAM_ARB_LOCK_EN adds per-port lock inputs)
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int RD_LAT = C_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
`ifdef RAM_ARB_LOCK_EN
  input  logic              i_a_lock,
  input  logic              i_b_lock,
`endif
  output logic              o_ram_wren,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic [DATA_W-1:0] i_ram_q
);

  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  port_e             r_rr;

  logic              w_a_elig;
  logic              w_b_elig;
  logic              w_a_blk;
  logic              w_b_blk;
  logic              w_win_vld;
  port_e             w_win;
  port_e             w_rr_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  tag_t              w_tag;

`ifdef RAM_ARB_LOCK_EN
  port_e r_last;

  // A lock only counts for the port that owned the previous grant.
  assign w_a_blk = (r_last == PORT_B) && i_b_lock && i_b_req;
  assign w_b_blk = (r_last == PORT_A) && i_a_lock && i_a_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_last <= PORT_A;
    else if (w_win_vld) r_last <= w_win;
  end
`else
  assign w_a_blk = 1'b0;
  assign w_b_blk = 1'b0;
`endif

  // A port whose gnt is high now still shows the request just taken.
  always_comb begin
    w_a_elig  = i_a_req && !r_a_gnt && !w_a_blk;
    w_b_elig  = i_b_req && !r_b_gnt && !w_b_blk;
    w_win_vld = w_a_elig || w_b_elig;
    w_win     = PORT_A;
    w_rr_nxt  = r_rr;
    if (w_a_elig && w_b_elig) begin
      w_win    = r_rr;
      w_rr_nxt = other_port(r_rr);
    end else if (w_b_elig) begin
      w_win = PORT_B;
    end
    w_we   = (w_win == PORT_B) ? i_b_we    : i_a_we;
    w_addr = (w_win == PORT_B) ? i_b_addr  : i_a_addr;
    w_data = (w_win == PORT_B) ? i_b_wdata : i_a_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rr    <= PORT_A;
    end else begin
      r_a_gnt <= w_win_vld && (w_win == PORT_A);
      r_b_gnt <= w_win_vld && (w_win == PORT_B);
      r_rr    <= w_rr_nxt;
      if (w_win_vld) begin
        r_wren <= w_we;
        r_addr <= w_addr;
        r_data <= w_data;
      end else begin
        r_wren <= 1'b0;
      end
    end
  end

  // Tag enters the delay line in the cycle the access is on the RAM pins.
  always_comb begin
    w_tag       = '0;
    w_tag.valid = (r_a_gnt || r_b_gnt) && !r_wren;
    w_tag.port  = r_b_gnt ? PORT_B : PORT_A;
  end

  ram_arb_rdpipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk        (clk),
    .rst        (rst),
    .i_tag      (w_tag),
    .i_ram_q    (i_ram_q),
    .o_a_rvalid (o_a_rvalid),
    .o_a_rdata  (o_a_rdata),
    .o_b_rvalid (o_b_rvalid),
    .o_b_rdata  (o_b_rdata)
  );

  assign o_a_gnt    = r_a_gnt;
  assign o_b_gnt    = r_b_gnt;
  assign o_ram_wren = r_wren;
  assign o_ram_addr = r_addr;
  assign o_ram_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter : self-checking bench for ram_arbiter with a behavioural RAM
// Revision       : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int RD_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wren;
  logic [7:0] a_rdata, b_rdata, ram_addr, ram_data, ram_q;
`ifdef RAM_ARB_LOCK_EN
  logic       a_lock = 0, b_lock = 0;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
`ifdef RAM_ARB_LOCK_EN
    .i_a_lock(a_lock), .i_b_lock(b_lock),
`endif
    .o_ram_wren(ram_wren), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
    .i_ram_q(ram_q)
  );

  // Single-port RAM: registered address, registered output, old-data on collision.
  logic [7:0] mem [256];
  logic [7:0] r_qaddr;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    r_qaddr <= ram_addr;
    ram_q   <= mem[r_qaddr];
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (sampled on the falling edge) ----------
  typedef struct {int due; logic [7:0] d;} rd_t;
  rd_t        qa[$], qb[$];
  logic [7:0] shadow [256];
  int         cyc = 0, contend = 0, rva_cnt = 0, rvb_cnt = 0;
  logic       m_pea = 0, m_peb = 0, m_wren = 0;
  logic       m_awe, m_bwe;
  logic [7:0] m_aad, m_awd, m_bad, m_bwd, m_addr = 0, m_data = 0;
  port_e      m_last = PORT_A;
  logic       m_pal = 0, m_pbl = 0;

  initial for (int i = 0; i < 256; i++) begin
    mem[i]    = pat(i);
    shadow[i] = pat(i);
  end

  always @(negedge clk) begin
    logic ea, eb, wa, wb;
    cyc++;
    if (a_rvalid) rva_cnt++;
    if (b_rvalid) rvb_cnt++;
    if (rst) begin
      qa.delete(); qb.delete();
      contend = 0; m_pea = 0; m_peb = 0; m_wren = 0;
      m_addr = 0; m_data = 0; m_last = PORT_A; m_pal = 0; m_pbl = 0;
    end else begin
      ea = m_pea && !(m_last == PORT_B && m_pbl);
      eb = m_peb && !(m_last == PORT_A && m_pal);
      wa = 0; wb = 0;
      if (ea && eb) begin
        if (contend % 2 == 0) wa = 1; else wb = 1;
        contend++;
      end else if (ea) wa = 1;
      else if (eb) wb = 1;
      chk("mdl_a_gnt", a_gnt, wa);
      chk("mdl_b_gnt", b_gnt, wb);
      m_wren = 0;
      if (wa || wb) begin
        m_wren = wa ? m_awe : m_bwe;
        m_addr = wa ? m_aad : m_bad;
        m_data = wa ? m_awd : m_bwd;
        m_last = wa ? PORT_A : PORT_B;
        if (m_wren) shadow[m_addr] = m_data;
        else if (wa) qa.push_back('{cyc + RD_LAT + 1, shadow[m_addr]});
        else         qb.push_back('{cyc + RD_LAT + 1, shadow[m_addr]});
      end
      chk("mdl_wren", ram_wren, m_wren);
      chk("mdl_addr", ram_addr, m_addr);
      chk("mdl_data", ram_data, m_data);
      if (qa.size() > 0 && qa[0].due == cyc) begin
        chk("mdl_a_rvalid", a_rvalid, 1);
        chk("mdl_a_rdata", a_rdata, qa[0].d);
        void'(qa.pop_front());
      end else chk("mdl_a_rvalid", a_rvalid, 0);
      if (qb.size() > 0 && qb[0].due == cyc) begin
        chk("mdl_b_rvalid", b_rvalid, 1);
        chk("mdl_b_rdata", b_rdata, qb[0].d);
        void'(qb.pop_front());
      end else chk("mdl_b_rvalid", b_rvalid, 0);
      m_pea = a_req && !wa;
      m_peb = b_req && !wb;
`ifdef RAM_ARB_LOCK_EN
      m_pal = a_lock && a_req;
      m_pbl = b_lock && b_req;
`endif
    end
    m_awe = a_we; m_aad = a_addr; m_awd = a_wdata;
    m_bwe = b_we; m_bad = b_addr; m_bwd = b_wdata;
  end

  // ---------------- directed stimulus -------------------------------------
  typedef struct {
    logic ar, awe; logic [7:0] aad, awd;
    logic br, bwe; logic [7:0] bad_, bwd;
    logic eag, ebg, ewr; logic [7:0] ead;
  } vec_t;
  vec_t tbl [12];

  task automatic idle();
    a_req = 0; b_req = 0;
`ifdef RAM_ARB_LOCK_EN
    a_lock = 0; b_lock = 0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_gnt"}, a_gnt, 0);     chk({tag, "_b_gnt"}, b_gnt, 0);
    chk({tag, "_a_rvalid"}, a_rvalid, 0); chk({tag, "_b_rvalid"}, b_rvalid, 0);
    chk({tag, "_wren"}, ram_wren, 0);   chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, ram_data, 0);
    chk({tag, "_a_rdata"}, a_rdata, 0); chk({tag, "_b_rdata"}, b_rdata, 0);
  endtask

  initial begin
    int steps, n, rv0;
    #2 rst = 1;
    step();
    chk_zero("reset");
    repeat (2) step();
    rst = 0;
    step();

    // A alone streams 256 reads; one grant every other cycle.
    a_req = 1; a_we = 0; a_addr = 0;
    steps = 0; n = 0; rv0 = rva_cnt;
    while (n < 256 && steps < 600) begin
      step(); steps++;
      if (a_gnt) begin
        n++;
        a_addr = 8'(n);
        if (n == 256) a_req = 0;
      end
    end
    chk("rd256_grants", n, 256);
    chk("rd256_cycles", steps, 511);
    repeat (6) step();
    chk("rd256_rvalids", rva_cnt - rv0, 256);

    // Write 0x5A then read it back with exact latency.
    do_reset();
    a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h5A;
    step(); chk("wr_gnt", a_gnt, 1);
    a_req = 0; step();
    a_req = 1; a_we = 0; a_addr = 8'h10;
    step(); chk("rd_gnt", a_gnt, 1);
    a_req = 0;
    step(); chk("rd_lat1", a_rvalid, 0);
    step(); chk("rd_lat2", a_rvalid, 0);
    step(); chk("rd_lat3", a_rvalid, 1); chk("rd_data", a_rdata, 8'h5A);
    step(); chk("rd_pulse", a_rvalid, 0); chk("rd_hold", a_rdata, 8'h5A);

    // Per-cycle table right after a reset.
    tbl[0]  = '{1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 1,0,1,8'h10};
    tbl[1]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10};
    tbl[2]  = '{1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10};
    tbl[3]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h10};
    tbl[4]  = '{1,1,8'h20,8'h11, 1,1,8'h30,8'h22, 1,0,1,8'h20};
    tbl[5]  = '{0,0,8'h00,8'h00, 1,1,8'h30,8'h22, 0,1,1,8'h30};
    tbl[6]  = '{1,0,8'h40,8'h00, 1,0,8'h50,8'h00, 1,0,0,8'h40};
    tbl[7]  = '{0,0,8'h00,8'h00, 1,0,8'h50,8'h00, 0,1,0,8'h50};
    tbl[8]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h50};
    tbl[9]  = '{1,1,8'h60,8'h33, 1,1,8'h70,8'h44, 0,1,1,8'h70};
    tbl[10] = '{1,1,8'h60,8'h33, 0,0,8'h00,8'h00, 1,0,1,8'h60};
    tbl[11] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h60};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a_req = tbl[i].ar; a_we = tbl[i].awe; a_addr = tbl[i].aad; a_wdata = tbl[i].awd;
      b_req = tbl[i].br; b_we = tbl[i].bwe; b_addr = tbl[i].bad_; b_wdata = tbl[i].bwd;
      step();
      chk($sformatf("tbl%0d_a_gnt", i), a_gnt, tbl[i].eag);
      chk($sformatf("tbl%0d_b_gnt", i), b_gnt, tbl[i].ebg);
      chk($sformatf("tbl%0d_wren", i), ram_wren, tbl[i].ewr);
      chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].ead);
    end
    idle();
    repeat (5) step();

    // Both ports request continuously: strict A,B alternation, no idle cycle.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 8'h80; b_req = 1; b_we = 1; b_addr = 8'hC0; b_wdata = 8'h01;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("alt%0d_a", k), a_gnt, (k % 2 == 0));
      chk($sformatf("alt%0d_b", k), b_gnt, (k % 2 == 1));
      chk($sformatf("alt%0d_addr", k), ram_addr, (k % 2 == 0) ? a_addr : b_addr);
      if (a_gnt) a_addr = a_addr + 1;
      if (b_gnt) begin b_addr = b_addr + 1; b_wdata = b_wdata + 1; end
    end
    idle();
    repeat (5) step();

    // Reset lands with two reads in flight.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 8'h05; b_req = 1; b_we = 0; b_addr = 8'h06;
    step(); chk("rst_mid_a_gnt", a_gnt, 1);
    a_req = 0;
    step(); chk("rst_mid_b_gnt", b_gnt, 1);
    b_req = 0;
    step();
    rst = 1;
    #1 chk_zero("rst_mid");
    repeat (2) step();
    rst = 0;
    rv0 = rva_cnt + rvb_cnt;
    repeat (10) step();
    chk("rst_mid_no_rvalid", rva_cnt + rvb_cnt - rv0, 0);
    a_req = 1; a_we = 0; a_addr = 8'h07; b_req = 1; b_we = 0; b_addr = 8'h08;
    step(); chk("rst_mid_rr_a", a_gnt, 1); chk("rst_mid_rr_b", b_gnt, 0);
    idle();
    repeat (5) step();

`ifdef RAM_ARB_LOCK_EN
    // A locks for four accesses while B waits.
    do_reset();
    a_req = 1; a_lock = 1; a_we = 1; a_addr = 8'h90; a_wdata = 8'h00;
    b_req = 1; b_we = 0; b_addr = 8'h91;
    n = 0; steps = 0;
    while (n < 4 && steps < 40) begin
      step(); steps++;
      chk("lock_b_blocked", b_gnt, 0);
      if (a_gnt) begin
        n++;
        a_addr = a_addr + 1;
        if (n == 4) begin a_lock = 0; a_req = 0; end
      end
    end
    chk("lock_a_count", n, 4);
    chk("lock_cycles", steps, 7);
    step(); chk("lock_b_after", b_gnt, 1);
    idle();
    repeat (5) step();
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!a_req || a_gnt) begin
        a_req = ($urandom % 3) != 0; a_we = $urandom % 2;
        a_addr = 8'($urandom % 16); a_wdata = 8'($urandom);
      end
      if (!b_req || b_gnt) begin
        b_req = ($urandom % 3) != 0; b_we = $urandom % 2;
        b_addr = 8'($urandom % 16); b_wdata = 8'($urandom);
      end
      step();
    end
    idle();
    repeat (8) step();
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port 256x8 on-chip RAM between a writer/reader pair, e.g. the fill sequencer and a display/readback engine. It accepts independent request/hold handshakes from ports A and B, grants one RAM access per cycle with round-robin fairness, drives the RAM's wren/address/data inputs from registers, and returns read data to the owning port after the fixed RAM read latency.

## Interface
- ADDR_W, 8: RAM address width (256 words).
- DATA_W, 8: RAM data width.
- RD_LAT, 2: cycles from RAM address registered to q valid (registered address plus registered output).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A access request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  one-cycle pulse: A's access issued to the RAM this cycle.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds A's read result.
- a_rdata  out  DATA_W  port A read data.
- b_*: identical set for port B.
- ram_wren  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data.

## Operation
- Arbitration evaluated every cycle from sampled requests; eligible port = req high and its gnt not high this cycle (prevents re-granting a stale held request).
- One eligible port: it wins. Both eligible: the port indicated by rr_ptr wins; rr_ptr then points to the loser.
- Winner's we/addr/wdata registered into ram_wren/ram_addr/ram_data; winner's gnt pulses the same cycle those registers update.
- No winner: ram_wren forced 0; ram_addr/ram_data hold their last value.
- Requester may drop or change req/fields the cycle after gnt.
- Read grants push {port id} into a RD_LAT-deep tag pipeline; on exit, ram_q is registered into that port's rdata and its rvalid pulses. Write grants push an empty tag.
- rdata holds its value between rvalid pulses.
- Reads and writes to the same address in consecutive cycles are issued in grant order; RAM read-during-write behaviour is old-data and is not hidden by the arbiter.

## Timing
- Reset: a_gnt, b_gnt, a_rvalid, b_rvalid, ram_wren = 0; ram_addr, ram_data, a_rdata, b_rdata = 0; rr_ptr = A; tag pipeline empty.
- Grant latency: req sampled high at edge N gives gnt high in cycle N+1 (no contention).
- Read latency: gnt at cycle G gives rvalid at cycle G+RD_LAT+1.
- Throughput: the RAM can accept one access per cycle overall; a single port achieves at most one access every 2 cycles.
- Reset mid-operation: all in-flight reads are discarded and no rvalid is produced after reset deassertion until a new read is granted.

## Configuration
- RAM_ARB_LOCK_EN defined: adds a_lock and b_lock inputs (1 bit each). While the last-granted port holds lock high with req high, the other port is ineligible. The locked port gets every other cycle; the intermediate cycles are idle. Releasing lock restores round-robin on the next evaluation.
- RAM_ARB_LOCK_EN undefined: no lock ports; pure round-robin.

## Structure
- Package ram_arb_pkg: ADDR_W/DATA_W defaults, port-id enum (PORT_A, PORT_B), and the tag struct {valid, port}.
- Sub-module ram_arb_rdpipe: RD_LAT-stage tag shift register plus output rdata/rvalid registers, with asynchronous clear on rst.

## Test plan
- Reset asserted mid-stream with 2 reads in flight -> all outputs 0, no rvalid after release, rr_ptr = A.
- A writes 0x5A to addr 0x10, then reads addr 0x10 -> a_gnt at N+1 both times, a_rvalid with a_rdata = 0x5A exactly RD_LAT+1 cycles after the read gnt.
- A and B both request continuously -> gnts alternate A, B, A, B…, ram_wren/addr match the winner every cycle, no idle cycles.
- A only, req held continuously for 256 reads of addr 0..255 -> gnt every 2nd cycle, 256 rvalids in order, data matches the preloaded pattern.
- Simultaneous first requests after reset -> A wins; the next contended cycle B wins.
- With RAM_ARB_LOCK_EN: A locks for 4 accesses while B requests -> B gets no gnt until the cycle after a_lock falls.
